// File: rtl/level_classifier_pkg.sv
// Shared types for the multi-lane CABAC level classifier: lane case encoding,
// the minimum effective base level and a per-lane result record.
package level_classifier_pkg;

    typedef enum logic [1:0] {
        ZERO     = 2'd0,
        ONE      = 2'd1,
        TWO      = 2'd2,
        BASEPLUS = 2'd3
    } lvl_case_e;

    localparam int MIN_BASE_LEVEL = 3;
    localparam int SYM_W          = 16;

    typedef struct packed {
        lvl_case_e        lvl_case;
        logic [SYM_W-1:0] sym;
    } lane_s;

endpackage

// File: rtl/level_lane_classify.sv
// Combinational single-lane classifier: maps one absolute level to its case
// and remainder symbol against the clamped base level.
module level_lane_classify
    import level_classifier_pkg::*;
#(
    parameter int ABS_W  = 16,
    parameter int BASE_W = 8
) (
    input  logic [ABS_W-1:0]  level,
    input  logic [BASE_W-1:0] base,
    input  logic              en,
    output lvl_case_e         lvl_case,
    output logic [ABS_W-1:0]  sym
);

    localparam int W = (ABS_W > BASE_W) ? ABS_W : BASE_W;

    logic [W-1:0] level_x;
    logic [W-1:0] eb_x;

    // A base below MIN_BASE_LEVEL is clamped up, so level 2 is always TWO.
    always_comb begin
        level_x  = W'(level);
        eb_x     = (base < BASE_W'(MIN_BASE_LEVEL)) ? W'(MIN_BASE_LEVEL) : W'(base);
        lvl_case = ZERO;
        sym      = '0;
        if (en) begin
            if (level == '0) begin
                lvl_case = ZERO;
            end else if (level == ABS_W'(1)) begin
                lvl_case = ONE;
            end else if (level_x >= eb_x) begin
                lvl_case = BASEPLUS;
                sym      = ABS_W'(level_x - eb_x);
            end else begin
                lvl_case = TWO;
                sym      = level - ABS_W'(2);
            end
        end
    end

endmodule

// File: rtl/level_classifier_pipe.sv
// Two-stage globally stalled level classifier with Rice prefix/suffix split.
// Define LVLCLS_STATS_EN to add per-case saturating lane counters.
module level_classifier_pipe
    import level_classifier_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ABS_W  = 16,
    parameter int BASE_W = 8,
    parameter int PFX_W  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*ABS_W-1:0] in_abs,
    input  logic [LANES-1:0]       in_lane_en,
    input  logic [BASE_W-1:0]      in_base,
    input  logic [2:0]             in_rice,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*2-1:0]     out_case,
    output logic [LANES*ABS_W-1:0] out_sym,
    output logic [LANES*PFX_W-1:0] out_prefix,
    output logic [LANES*ABS_W-1:0] out_suffix,
    output logic [LANES-1:0]       out_escape,
    output logic                   out_last
`ifdef LVLCLS_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [31:0]            cnt_zero,
    output logic [31:0]            cnt_one,
    output logic [31:0]            cnt_two,
    output logic [31:0]            cnt_base
`endif
);

    localparam int PREFIX_MAX = (1 << PFX_W) - 1;

    logic adv;

    lvl_case_e        c1_case [LANES];
    logic [ABS_W-1:0] c1_sym  [LANES];

    logic             s1_valid;
    lvl_case_e        s1_case [LANES];
    logic [ABS_W-1:0] s1_sym  [LANES];
    logic [2:0]       s1_rice;
    logic             s1_last;
    logic [LANES-1:0] s1_en;

    logic [ABS_W-1:0] c2_shift  [LANES];
    logic [PFX_W-1:0] c2_prefix [LANES];
    logic [ABS_W-1:0] c2_suffix [LANES];
    logic [LANES-1:0] c2_escape;

    // Whole pipeline moves together whenever the output slot is free.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        level_lane_classify #(
            .ABS_W  (ABS_W),
            .BASE_W (BASE_W)
        ) u_classify (
            .level    (in_abs[l*ABS_W +: ABS_W]),
            .base     (in_base),
            .en       (in_lane_en[l]),
            .lvl_case (c1_case[l]),
            .sym      (c1_sym[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_rice  <= '0;
            s1_last  <= 1'b0;
            s1_en    <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_case[l] <= ZERO;
                s1_sym[l]  <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_rice  <= in_rice;
            s1_last  <= in_last;
            s1_en    <= in_lane_en;
            for (int l = 0; l < LANES; l++) begin
                s1_case[l] <= c1_case[l];
                s1_sym[l]  <= c1_sym[l];
            end
        end
    end

    // Suffix uses the full symbol even when the prefix saturates to escape.
    always_comb begin
        c2_escape = '0;
        for (int l = 0; l < LANES; l++) begin
            c2_shift[l]  = s1_sym[l] >> s1_rice;
            c2_prefix[l] = '0;
            c2_suffix[l] = '0;
            if (s1_en[l]) begin
                c2_suffix[l] = s1_sym[l] & ~({ABS_W{1'b1}} << s1_rice);
                if (c2_shift[l] > ABS_W'(PREFIX_MAX)) begin
                    c2_prefix[l] = PFX_W'(PREFIX_MAX);
                    c2_escape[l] = 1'b1;
                end else begin
                    c2_prefix[l] = PFX_W'(c2_shift[l]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_case   <= '0;
            out_sym    <= '0;
            out_prefix <= '0;
            out_suffix <= '0;
            out_escape <= '0;
            out_last   <= 1'b0;
        end else if (adv) begin
            out_valid  <= s1_valid;
            out_last   <= s1_last;
            out_escape <= c2_escape;
            for (int l = 0; l < LANES; l++) begin
                out_case[2*l +: 2]           <= s1_case[l];
                out_sym[l*ABS_W +: ABS_W]    <= s1_sym[l];
                out_prefix[l*PFX_W +: PFX_W] <= c2_prefix[l];
                out_suffix[l*ABS_W +: ABS_W] <= c2_suffix[l];
            end
        end
    end

`ifdef LVLCLS_STATS_EN
    localparam int CW = $clog2(LANES + 1);

    logic [LANES-1:0] out_en;
    logic [CW-1:0]    stat_inc [4];

    function automatic logic [31:0] sat_add(input logic [31:0] c, input logic [CW-1:0] d);
        logic [32:0] s;
        s = {1'b0, c} + 33'(d);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en <= '0;
        end else if (adv) begin
            out_en <= s1_en;
        end
    end

    // Disabled lanes also read ZERO, so only enabled lanes are counted.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            stat_inc[k] = '0;
        end
        for (int l = 0; l < LANES; l++) begin
            if (out_en[l]) begin
                stat_inc[out_case[2*l +: 2]] = stat_inc[out_case[2*l +: 2]] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            cnt_zero <= '0;
            cnt_one  <= '0;
            cnt_two  <= '0;
            cnt_base <= '0;
        end else if (out_valid && out_ready) begin
            cnt_zero <= sat_add(cnt_zero, stat_inc[0]);
            cnt_one  <= sat_add(cnt_one,  stat_inc[1]);
            cnt_two  <= sat_add(cnt_two,  stat_inc[2]);
            cnt_base <= sat_add(cnt_base, stat_inc[3]);
        end
    end
`endif

endmodule

// File: tb/tb_level_classifier_pipe.sv
// Directed bench for level_classifier_pipe: queue-based reference model plus
// hand-computed literal beats. Define LVLCLS_STATS_EN to also exercise counters.
module tb_level_classifier_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_abs;
    logic [3:0]  in_lane_en;
    logic [7:0]  in_base;
    logic [2:0]  in_rice;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_case;
    logic [63:0] out_sym;
    logic [19:0] out_prefix;
    logic [63:0] out_suffix;
    logic [3:0]  out_escape;
    logic        out_last;
`ifdef LVLCLS_STATS_EN
    logic        stats_clr;
    logic [31:0] cnt_zero, cnt_one, cnt_two, cnt_base;
`endif

    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] sym;
        logic [19:0] pfx;
        logic [63:0] sfx;
        logic [3:0]  esc;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;
    int   ready_mode = 0;
    logic ready_force = 1'b1;
    logic pat_bit = 1'b1;
    logic [3:0] pat = 4'b1001;
    int   pat_cnt = 0;
    logic stall_prev = 1'b0;

    level_classifier_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_abs     (in_abs),
        .in_lane_en (in_lane_en),
        .in_base    (in_base),
        .in_rice    (in_rice),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_case   (out_case),
        .out_sym    (out_sym),
        .out_prefix (out_prefix),
        .out_suffix (out_suffix),
        .out_escape (out_escape),
`ifdef LVLCLS_STATS_EN
        .stats_clr  (stats_clr),
        .cnt_zero   (cnt_zero),
        .cnt_one    (cnt_one),
        .cnt_two    (cnt_two),
        .cnt_base   (cnt_base),
`endif
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // Downstream ready: either forced by the sequence or the 1,0,0,1 pattern.
    assign out_ready = (ready_mode == 1) ? pat_bit : ready_force;

    always @(posedge clk) begin
        #1;
        pat_cnt++;
        pat_bit = pat[pat_cnt % 4];
    end

    // Reference: classify from the rules with integer arithmetic.
    function automatic exp_t model_beat(input logic [63:0] a_v, input logic [3:0] en,
                                        input logic [7:0] base, input logic [2:0] rice,
                                        input logic last);
        exp_t e;
        int eb, a, cls, s, p, r, dv;
        e  = '0;
        eb = (int'(base) < 3) ? 3 : int'(base);
        dv = 1 << rice;
        for (int l = 0; l < 4; l++) begin
            a = int'(a_v[l*16 +: 16]);
            if (!en[l])       begin cls = 0; s = 0;      end
            else if (a == 0)  begin cls = 0; s = 0;      end
            else if (a == 1)  begin cls = 1; s = 0;      end
            else if (a >= eb) begin cls = 3; s = a - eb; end
            else              begin cls = 2; s = a - 2;  end
            p = s / dv;
            r = s % dv;
            e.esc[l] = (p > 31);
            if (p > 31) p = 31;
            e.c[l*2 +: 2]    = 2'(cls);
            e.sym[l*16 +: 16] = 16'(s);
            e.pfx[l*5 +: 5]   = 5'(p);
            e.sfx[l*16 +: 16] = 16'(r);
        end
        e.last = last;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
    task automatic applyStimulus(input logic [63:0] a, input logic [3:0] en, input logic [7:0] b,
                                 input logic [2:0] r, input logic last);
        int   guard;
        logic hs;
        guard = 0;
        hs = 1'b0;
        in_valid = 1'b1; in_abs = a; in_lane_en = en; in_base = b; in_rice = r; in_last = last;
        while (!hs && guard < 100) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!hs) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL handshake_timeout: got no accept, required accept within 100 cycles");
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic literal_beat(input string tag, input logic [63:0] a, input logic [3:0] en,
                                input logic [7:0] b, input logic [2:0] r,
                                input logic [7:0] xc, input logic [63:0] xs, input logic [19:0] xp,
                                input logic [63:0] xf, input logic [3:0] xe);
        applyStimulus(a, en, b, r, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_not_early"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_valid"},  64'(out_valid),  64'd1);
        checkOutput({tag, "_case"},   64'(out_case),   64'(xc));
        checkOutput({tag, "_sym"},    out_sym,         xs);
        checkOutput({tag, "_prefix"}, 64'(out_prefix), 64'(xp));
        checkOutput({tag, "_suffix"}, out_suffix,      xf);
        checkOutput({tag, "_escape"}, 64'(out_escape), 64'(xe));
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_pop++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model_beat(in_abs, in_lane_en, in_base, in_rice, in_last));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) checkOutput("hold_valid", 64'(out_valid), 64'd1);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_beat", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    checkOutput("mon_case",   64'(out_case),   64'(e.c));
                    checkOutput("mon_sym",    out_sym,         e.sym);
                    checkOutput("mon_prefix", 64'(out_prefix), 64'(e.pfx));
                    checkOutput("mon_suffix", out_suffix,      e.sfx);
                    checkOutput("mon_escape", 64'(out_escape), 64'(e.esc));
                    checkOutput("mon_last",   64'(out_last),   64'(e.last));
                end
            end
            stall_prev = out_valid && !out_ready;
        end
    end

    initial begin
        #200000;
        n_vec++;
        n_err++;
        $display("[TB] FAIL watchdog: got no completion, required finish before 200000 time units");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        exp_t pin;
        int   pops0;
        rst = 1'b1; in_valid = 1'b0; in_abs = '0; in_lane_en = '0; in_base = '0;
        in_rice = '0; in_last = 1'b0;
`ifdef LVLCLS_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_case",  64'(out_case),  64'd0);
        checkOutput("reset_sym",   out_sym,        64'd0);
        checkOutput("reset_last",  64'(out_last),  64'd0);
        @(posedge clk);
        #1;

        pin = model_beat({16'd300, 16'd2, 16'd6, 16'd5}, 4'hF, 8'd6, 3'd2, 1'b0);
        checkOutput("pin_model_prefix", 64'(pin.pfx), 64'({5'd31, 15'd0}));
        checkOutput("pin_model_suffix", pin.sfx, {16'd2, 32'd0, 16'd3});

        literal_beat("t1", {16'd7, 16'd2, 16'd1, 16'd0}, 4'hF, 8'd3, 3'd0,
                     8'hE4, {16'd4, 48'd0}, {5'd4, 15'd0}, 64'd0, 4'b0000);
        literal_beat("t2", {16'd300, 16'd2, 16'd6, 16'd5}, 4'hF, 8'd6, 3'd2,
                     8'hEE, {16'd294, 16'd0, 16'd0, 16'd3}, {5'd31, 15'd0},
                     {16'd2, 32'd0, 16'd3}, 4'b1000);
        literal_beat("t3", {4{16'd3}}, 4'b0101, 8'd1, 3'd1,
                     8'h33, 64'd0, 20'd0, 64'd0, 4'b0000);

        // Back-pressured stream of eight beats; only the last carries in_last.
        pops0 = n_pop;
        ready_mode = 1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus({16'(k*1000 + 5), 16'(k*37), 16'(k + 1), 16'(k % 3)},
                          (k == 5) ? 4'b1101 : 4'hF, 8'(k*2), 3'(k), k == 7);
        end
        in_valid = 1'b0;
        wait_drain();
        checkOutput("stream_count", 64'(n_pop - pops0), 64'd8);
        @(posedge clk);
        #1 ready_mode = 0;

        // Reset with two beats in flight.
        applyStimulus({16'd4, 16'd3, 16'd2, 16'd1}, 4'hF, 8'd3, 3'd0, 1'b0);
        applyStimulus({16'd9, 16'd8, 16'd7, 16'd6}, 4'hF, 8'd3, 3'd1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("in_ready_mid_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_flush_valid",  64'(out_valid),  64'd0);
        checkOutput("rst_flush_case",   64'(out_case),   64'd0);
        checkOutput("rst_flush_sym",    out_sym,         64'd0);
        checkOutput("rst_flush_prefix", 64'(out_prefix), 64'd0);
        checkOutput("rst_flush_suffix", out_suffix,      64'd0);
        checkOutput("rst_flush_escape", 64'(out_escape), 64'd0);
        checkOutput("rst_flush_last",   64'(out_last),   64'd0);
        @(posedge clk);
        #1;
        applyStimulus({16'd20, 16'd0, 16'd1, 16'd5}, 4'hF, 8'd4, 3'd2, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_not_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_latency", 64'(out_valid), 64'd1);
        wait_drain();
        @(posedge clk);
        #1;

`ifdef LVLCLS_STATS_EN
        stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus({16'd9, 16'd2, 16'd1, 16'd0}, 4'hF, 8'd3, 3'd0, 1'b0);
        in_valid = 1'b0;
        wait_drain();
        checkOutput("cnt_zero_3", 64'(cnt_zero), 64'd3);
        checkOutput("cnt_one_3",  64'(cnt_one),  64'd3);
        checkOutput("cnt_two_3",  64'(cnt_two),  64'd3);
        checkOutput("cnt_base_3", 64'(cnt_base), 64'd3);
        @(posedge clk);
        #1 ready_force = 1'b0;
        applyStimulus({16'd9, 16'd2, 16'd1, 16'd0}, 4'hF, 8'd3, 3'd0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("cnt_stall_valid", 64'(out_valid), 64'd1);
        checkOutput("cnt_zero_stall",  64'(cnt_zero),  64'd3);
        @(posedge clk);
        #1;
        stats_clr = 1'b1;
        ready_force = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        checkOutput("cnt_zero_clr", 64'(cnt_zero), 64'd0);
        checkOutput("cnt_one_clr",  64'(cnt_one),  64'd0);
        checkOutput("cnt_two_clr",  64'(cnt_two),  64'd0);
        checkOutput("cnt_base_clr", 64'(cnt_base), 64'd0);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        $display("[TB] sequence complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/level_classifier_pipe.md
Name: level_classifier_pipe

Overview:
Multi-lane pipelined successor to the single-coefficient level classifier in the CABAC rate estimator. Each beat carries LANES absolute levels. Each level is classified as ZERO, ONE, TWO or BASEPLUS, and its remainder symbol is split into a Rice prefix/suffix for the bin-cost stage. A valid/ready stream with full back-pressure sits between the RDOQ coefficient scanner and the rate lookup.

Parameters:
LANES, 4, coefficients per beat
ABS_W, 16, width of each absolute level and of each symbol
BASE_W, 8, width of baseLevel
PFX_W, 5, prefix width; PREFIX_MAX = 2**PFX_W-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_abs  in  LANES*ABS_W  packed uiAbsLevel, lane 0 in LSBs
in_lane_en  in  LANES  per-lane enable
in_base  in  BASE_W  baseLevel shared by all lanes of the beat
in_rice  in  3  Rice parameter 0..7
in_last  in  1  last beat of block, passed through
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_case  out  LANES*2  0=ZERO 1=ONE 2=TWO 3=BASEPLUS
out_sym  out  LANES*ABS_W  remainder symbol
out_prefix  out  LANES*PFX_W  symbol>>rice, saturated
out_suffix  out  LANES*ABS_W  symbol & ((1<<rice)-1)
out_escape  out  LANES  prefix saturated
out_last  out  1  aligned in_last

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). While rst=1 at a clk edge, all pipeline valids and every output register clear to 0. in_ready is 0 during reset.
- Effective base: eb = max(in_base, 3). in_base < 3 is clamped, never an error.
- Classification per enabled lane (a = abs):
  - a==0: ZERO, sym=0
  - a==1: ONE, sym=0
  - a>=eb: BASEPLUS, sym=a-eb
  - otherwise (2<=a<eb): TWO, sym=a-2
- Disabled lanes output ZERO, sym=0, prefix=0, suffix=0, escape=0.
- Stage 1 registers case, sym, rice, last, lane_en.
- Stage 2 registers prefix/suffix/escape. prefix = sym>>rice. If that value exceeds PREFIX_MAX, prefix=PREFIX_MAX and escape=1. suffix is computed from the unsaturated sym.
- Latency: exactly 2 cycles from accepted beat to out_valid when out_ready=1 is held.
- Global-stall pipeline: adv = !out_valid | out_ready, and in_ready = adv (combinational).
  - When adv=0, both stages hold and outputs are stable.
  - When adv=1, stage 1 loads the input beat (valid = in_valid) and stage 2 loads stage 1.
- Throughput is 1 beat/cycle with out_ready=1.
- Bubbles propagate as invalid stages, with no collapsing. Output data with out_valid=0 is don't-care but deterministic.
- in_valid while in_ready=0: beat is not consumed; the source must hold it.
- Reset mid-stream discards all in-flight beats. No partial output.

Optional Feature:
LVLCLS_STATS_EN
- Defined: adds input stats_clr (1) and outputs cnt_zero, cnt_one, cnt_two, cnt_base (32 each).
  - On each output handshake, every counter adds the number of enabled lanes of its case.
  - Counters saturate at 2**32-1.
  - stats_clr=1 zeroes all counters, taking priority over increments in the same cycle.
  - rst also zeroes them.
- Undefined: these ports and counters do not exist; datapath behaviour is identical.

Decomposition:
- Package level_classifier_pkg holds:
  - typedef enum logic[1:0] lvl_case_e {ZERO, ONE, TWO, BASEPLUS}
  - constant MIN_BASE_LEVEL=3
  - packed struct lane_s {case, sym}
- One sub-module, level_lane_classify: combinational single-lane classifier instantiated LANES times in stage 1. Pipeline, handshake, Rice split and stats stay in the top.

Test Plan:
- LANES=4, base=3, rice=0, abs={0,1,2,7}, out_ready=1 -> after 2 cycles: case={0,1,2,3}, sym={0,0,0,4}, prefix={0,0,0,4}, suffix=0, escape=0.
- base=6, abs={5,6,2,300}, rice=2 -> case={2,3,2,3}, sym={3,0,0,294}, prefix={0,0,0,31}, escape lane3=1, suffix lane3=2.
- base=1 (clamped to 3), abs=3 -> BASEPLUS, sym=0. lane_en=4'b0101 -> lanes 1 and 3 read ZERO, sym 0.
- Stream 8 beats with out_ready toggling 1,0,0,1,... -> no beat lost or duplicated, order kept, outputs stable while stalled, out_last only on beat 8.
- Assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0, all outputs 0, subsequent beat emerges after 2 cycles.
- With LVLCLS_STATS_EN: 3 beats of abs={0,1,2,9}, base=3, then stats_clr together with a 4th handshake -> counters 3,3,3,3, then 0 (clear wins).
